// File: rtl/switch_poll_master.sv
// Avalon-MM read master that polls a switch PIO, debounces the bits and publishes sw_state/sw_changed.
// Optional feature: define SWITCH_POLL_IRQ_EN to add a sticky irq output with irq_ack clear.
module switch_poll_master #(
  parameter int         DATA_W         = 10,
  parameter int         POLL_DIV       = 50000,
  parameter int         READ_LATENCY   = 1,
  parameter int         STABLE_SAMPLES = 3,
  parameter logic [1:0] POLL_ADDR      = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
`ifdef SWITCH_POLL_IRQ_EN
  input  logic              irq_ack,
  output logic              irq,
`endif
  output logic [DATA_W-1:0] sw_state,
  output logic              sw_changed,
  output logic              busy
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int SW = $clog2(STABLE_SAMPLES + 1);

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(READ_LATENCY);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [PW-1:0]     r_poll_cnt;
  logic [PW-1:0]     w_poll_next;
  logic [LW-1:0]     r_lat_cnt;
  logic [LW-1:0]     w_lat_next;
  logic              r_read;
  logic              w_read_next;
  logic              r_busy;
  logic              w_busy_next;
  logic [1:0]        r_addr;
  logic              w_sample;

  logic [DATA_W-1:0] w_sample_bits;
  logic [DATA_W-1:0] r_cand;
  logic [DATA_W-1:0] w_cand_next;
  logic [SW-1:0]     r_stable;
  logic [SW-1:0]     w_stable_next;
  logic [DATA_W-1:0] r_sw;
  logic [DATA_W-1:0] w_sw_next;
  logic              r_changed;
  logic              w_changed_next;

  assign w_sample_bits = avm_readdata[DATA_W-1:0];

  // Upper readdata bits are deliberately discarded.
  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_poll_cnt <= '0;
      r_lat_cnt  <= '0;
      r_read     <= 1'b0;
      r_busy     <= 1'b0;
      r_addr     <= POLL_ADDR;
    end else begin
      r_state    <= w_state_next;
      r_poll_cnt <= w_poll_next;
      r_lat_cnt  <= w_lat_next;
      r_read     <= w_read_next;
      r_busy     <= w_busy_next;
      r_addr     <= POLL_ADDR;
    end
  end

  // Outputs are computed as next-cycle values so the bus signals come straight from flops.
  always_comb begin
    w_state_next = r_state;
    w_poll_next  = r_poll_cnt;
    w_lat_next   = r_lat_cnt;
    w_read_next  = 1'b0;
    w_busy_next  = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          if (r_poll_cnt == POLL_LAST) begin
            w_poll_next  = '0;
            w_state_next = REQ;
            w_read_next  = 1'b1;
            w_busy_next  = 1'b1;
          end else begin
            w_poll_next = r_poll_cnt + PW'(1);
          end
        end else begin
          w_poll_next = '0;
        end
      end
      REQ: begin
        w_busy_next = 1'b1;
        if (avm_waitrequest) begin
          w_read_next = 1'b1;
        end else begin
          w_state_next = WAIT;
          w_lat_next   = LW'(1);
        end
      end
      WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_sample     = 1'b1;
          w_state_next = IDLE;
          w_lat_next   = '0;
          w_poll_next  = '0;
        end else begin
          w_busy_next = 1'b1;
          w_lat_next  = r_lat_cnt + LW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_poll_next  = '0;
        w_lat_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand    <= '0;
      r_stable  <= '0;
      r_sw      <= '0;
      r_changed <= 1'b0;
    end else begin
      r_cand    <= w_cand_next;
      r_stable  <= w_stable_next;
      r_sw      <= w_sw_next;
      r_changed <= w_changed_next;
    end
  end

  // Publish decision uses the post-update candidate and count of this same sample.
  always_comb begin
    w_cand_next    = r_cand;
    w_stable_next  = r_stable;
    w_sw_next      = r_sw;
    w_changed_next = 1'b0;
    if (w_sample) begin
      if (w_sample_bits == r_cand) begin
        if (r_stable != STABLE_MAX) begin
          w_stable_next = r_stable + SW'(1);
        end
      end else begin
        w_cand_next   = w_sample_bits;
        w_stable_next = SW'(1);
      end
      if ((w_stable_next == STABLE_MAX) && (w_cand_next != r_sw)) begin
        w_sw_next      = w_cand_next;
        w_changed_next = 1'b1;
      end
    end
  end

`ifdef SWITCH_POLL_IRQ_EN
  logic r_irq;
  logic w_irq_next;

  // A new change outranks a coincident acknowledge.
  always_comb begin
    w_irq_next = r_irq;
    if (w_changed_next) begin
      w_irq_next = 1'b1;
    end else if (irq_ack) begin
      w_irq_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_irq_next;
    end
  end

  assign irq = r_irq;
`endif

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign sw_state    = r_sw;
  assign sw_changed  = r_changed;

endmodule

// File: tb/tb_switch_poll_master.sv
// Directed bench for switch_poll_master: poll timing, waitrequest stall, debounce, masking, enable and async reset.
module tb_switch_poll_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [9:0]  sw_state;
  logic        sw_changed;
  logic        busy;
`ifdef SWITCH_POLL_IRQ_EN
  logic        irq_ack = 1'b0;
  logic        irq;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  switch_poll_master #(
    .DATA_W(10),
    .POLL_DIV(4),
    .READ_LATENCY(1),
    .STABLE_SAMPLES(3),
    .POLL_ADDR(2'd2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
`ifdef SWITCH_POLL_IRQ_EN
    .irq_ack(irq_ack),
    .irq(irq),
`endif
    .sw_state(sw_state),
    .sw_changed(sw_changed),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One poll transaction: waits for the request, stalls it, then checks the debounced result.
  task automatic poll(input logic [31:0] data, input int waits, input logic [9:0] exp_state,
                      input logic exp_chg, input logic drop_en);
    int n;
    n = 0;
    while (avm_read !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (avm_read !== 1'b1) begin
      check_eq("req_timeout", {31'd0, avm_read}, 32'd1);
      return;
    end
    avm_readdata    = data;
    avm_waitrequest = (waits > 0);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check_eq("hold_read", {31'd0, avm_read}, 32'd1);
      check_eq("hold_addr", {30'd0, avm_address}, 32'd2);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_eq("accept_read", {31'd0, avm_read}, 32'd0);
    check_eq("wait_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("done_busy", {31'd0, busy}, 32'd0);
    check_eq("sw_state", {22'd0, sw_state}, {22'd0, exp_state});
    check_eq("sw_changed", {31'd0, sw_changed}, {31'd0, exp_chg});
    @(negedge clk);
    check_eq("pulse_end", {31'd0, sw_changed}, 32'd0);
    $display("[TB] poll data=0x%08h waits=%0d -> sw_state=0x%03h", data, waits, sw_state);
  endtask

  initial begin
    int reads;
    reset           = 1'b1;
    enable          = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_read", {31'd0, avm_read}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_sw_state", {22'd0, sw_state}, 32'd0);
    check_eq("rst_sw_changed", {31'd0, sw_changed}, 32'd0);
    check_eq("rst_addr", {30'd0, avm_address}, 32'd2);
    $display("[TB] reset values checked");

    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("idle_read", {31'd0, avm_read}, 32'd0);
    end
    @(negedge clk);
    check_eq("first_read", {31'd0, avm_read}, 32'd1);
    check_eq("first_busy", {31'd0, busy}, 32'd1);
    check_eq("first_addr", {30'd0, avm_address}, 32'd2);
    @(negedge clk);
    check_eq("first_accept", {31'd0, avm_read}, 32'd0);
    check_eq("first_wait_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("first_done_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("gap_read", {31'd0, avm_read}, 32'd0);
    end
    @(negedge clk);
    check_eq("period_read", {31'd0, avm_read}, 32'd1);
    $display("[TB] poll period checked");

    poll(32'h2A5, 0, 10'h000, 1'b0, 1'b0);
    poll(32'h2A5, 3, 10'h000, 1'b0, 1'b0);
    poll(32'h2A5, 0, 10'h2A5, 1'b1, 1'b0);

    poll(32'h001, 0, 10'h2A5, 1'b0, 1'b0);
    poll(32'h000, 0, 10'h2A5, 1'b0, 1'b0);
    poll(32'h001, 1, 10'h2A5, 1'b0, 1'b0);
    poll(32'h001, 0, 10'h2A5, 1'b0, 1'b0);
    poll(32'h001, 0, 10'h001, 1'b1, 1'b0);

    poll(32'hFFFFFC01, 0, 10'h001, 1'b0, 1'b0);
    poll(32'hFFFFFC01, 0, 10'h001, 1'b0, 1'b0);
    poll(32'hFFFFFC01, 0, 10'h001, 1'b0, 1'b0);

    poll(32'h001, 0, 10'h001, 1'b0, 1'b1);
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (avm_read) reads++;
    end
    check_eq("disabled_reads", reads, 32'd0);
    check_eq("disabled_busy", {31'd0, busy}, 32'd0);
    $display("[TB] enable drop checked, reads=%0d", reads);

    enable = 1'b1;
    reads = 0;
    while (avm_read !== 1'b1 && reads < 40) begin
      @(negedge clk);
      reads++;
    end
    check_eq("midreq_read", {31'd0, avm_read}, 32'd1);
    avm_waitrequest = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_read", {31'd0, avm_read}, 32'd0);
    check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_changed", {31'd0, sw_changed}, 32'd0);
    check_eq("async_rst_sw_state", {22'd0, sw_state}, 32'd0);
    $display("[TB] async reset mid-REQ checked");
    @(negedge clk);
    reset           = 1'b0;
    avm_waitrequest = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
